// File: rtl/fpga_pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_pwr_seq_pkg
// Description : Shared types and constants for the FPGA power/reset sequencer:
//               state encoding, reset-cause bit positions, clock-valid value
//               and counter sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_pwr_seq_pkg;

   // One-hot state encoding; any illegal pattern falls back to ST_WAIT_LOCK.
   typedef enum logic [4:0] {
      ST_WAIT_LOCK = 5'b00001,
      ST_STRETCH   = 5'b00010,
      ST_AON       = 5'b00100,
      ST_MAIN      = 5'b01000,
      ST_RUN       = 5'b10000
   } pwr_seq_state_e;

   // Bit positions inside rst_cause_o.
   localparam int CauseLockLoss = 0;
   localparam int CauseButton   = 1;
   localparam int CauseJtag     = 2;

   // {usb, io, core, slow} all valid.
   localparam logic [3:0] ClkValAll = 4'hF;

   // Bits needed to hold values 0 .. n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_pwr_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fpga_pwr_seq_if
// Description : Board-side inputs and emulated AST power outputs of the FPGA
//               power/reset sequencer. The master modport is the sequencer,
//               the slave modport is the board / SoC side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpga_pwr_seq_if;
   import fpga_pwr_seq_pkg::*;

   logic                 pll_locked_i;
   logic                 btn_rst_ni;
   logic                 jtag_srst_ni;
   logic                 aon_pok_o;
   logic                 main_pok_o;
   logic [3:0]           clk_val_o;
   logic                 sys_rst_no;
   logic [CauseJtag:0]   rst_cause_o;
   logic                 lock_timeout_o;

   modport master (
      input  pll_locked_i,
      input  btn_rst_ni,
      input  jtag_srst_ni,
      output aon_pok_o,
      output main_pok_o,
      output clk_val_o,
      output sys_rst_no,
      output rst_cause_o,
      output lock_timeout_o
   );

   modport slave (
      output pll_locked_i,
      output btn_rst_ni,
      output jtag_srst_ni,
      input  aon_pok_o,
      input  main_pok_o,
      input  clk_val_o,
      input  sys_rst_no,
      input  rst_cause_o,
      input  lock_timeout_o
   );

endinterface
`default_nettype wire

// File: rtl/fpga_pwr_seq_debounce.sv
`default_nettype none
// ============================================================================
// Module      : fpga_pwr_seq_debounce
// Description : Synchronizer chain plus debounce filter for the board reset
//               button. The stable value starts at 0 (pressed) so the system
//               is held in reset until a release has been seen long enough.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_pwr_seq_debounce
   import fpga_pwr_seq_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
   input  wire logic clk_i,
   input  wire logic rst_i,
   input  wire logic raw_i,
   output logic      db_o
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_stable;
   logic                   w_sample;

   assign w_sample = r_sync[SYNC_STAGES-1];

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
      end
   end

   // Accept a new level only after it has differed from the stable value for
   // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (w_sample == r_stable) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_stable <= w_sample;
         r_cnt    <= '0;
      end else if (r_cnt != '1) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign db_o = r_stable;

endmodule
`default_nettype wire

// File: rtl/fpga_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : fpga_pwr_seq
// Description : FPGA power/reset sequencer. Waits for PLL lock, a debounced
//               button release and JTAG reset deassertion, then raises
//               aon_pok, main_pok/clk_val and finally releases sys_rst_no.
//               Any fault drops all power outputs on the next clock edge.
//               Optional feature macro: PWR_SEQ_LOCK_TIMEOUT_EN adds a sticky
//               PLL lock-timeout flag on lock_timeout_o.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_pwr_seq
   import fpga_pwr_seq_pkg::*;
#(
   parameter int SYNC_STAGES         = 2,
   parameter int DEBOUNCE_CYCLES     = 50000,
   parameter int STRETCH_CYCLES      = 256,
   parameter int AON_TO_MAIN_CYCLES  = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000
) (
   input  wire logic        clk_i,
   input  wire logic        rst_i,
   fpga_pwr_seq_if.master   pwr
);

   localparam int c_CNT_W =
      cnt_width(max3(DEBOUNCE_CYCLES, STRETCH_CYCLES, AON_TO_MAIN_CYCLES));
   localparam logic [c_CNT_W-1:0] c_STRETCH_LAST = c_CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'(AON_TO_MAIN_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic [SYNC_STAGES-1:0] r_jtag_sync;
   logic                   w_lock_s;
   logic                   w_jtag_s;
   logic                   w_btn_db;
   logic [CauseJtag:0]     w_fault_vec;
   logic                   w_fault;

   pwr_seq_state_e         r_state;
   pwr_seq_state_e         w_state_nxt;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [c_CNT_W-1:0]     w_cnt_nxt;
   logic                   w_cause_load;
   logic [CauseJtag:0]     r_rst_cause;

   logic                   w_aon_pok;
   logic                   w_main_pok;
   logic [3:0]             w_clk_val;
   logic                   w_sys_rst_n;

   // Lock and JTAG reset are level signals that need no filtering.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock_sync <= '0;
         r_jtag_sync <= '0;
      end else begin
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pwr.pll_locked_i};
         r_jtag_sync <= {r_jtag_sync[SYNC_STAGES-2:0], pwr.jtag_srst_ni};
      end
   end

   assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
   assign w_jtag_s = r_jtag_sync[SYNC_STAGES-1];

   fpga_pwr_seq_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (c_CNT_W)
   ) u_btn_debounce (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .raw_i (pwr.btn_rst_ni),
      .db_o  (w_btn_db)
   );

   assign w_fault_vec[CauseLockLoss] = ~w_lock_s;
   assign w_fault_vec[CauseButton]   = ~w_btn_db;
   assign w_fault_vec[CauseJtag]     = ~w_jtag_s;
   assign w_fault                    = |w_fault_vec;

   // State and sequencing counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_WAIT_LOCK;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: every active state tears down to ST_WAIT_LOCK on fault;
   // only a fault out of RUN is recorded as a reset cause.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_cause_load = 1'b0;
      case (r_state)
         ST_WAIT_LOCK: begin
            w_cnt_nxt = '0;
            if (!w_fault) begin
               w_state_nxt = ST_STRETCH;
            end
         end
         ST_STRETCH: begin
            if (w_fault) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_STRETCH_LAST) begin
               w_state_nxt = ST_AON;
               w_cnt_nxt   = '0;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_AON: begin
            if (w_fault) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_GAP_LAST) begin
               w_state_nxt = ST_MAIN;
               w_cnt_nxt   = '0;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_MAIN: begin
            if (w_fault) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_GAP_LAST) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            w_cnt_nxt = '0;
            if (w_fault) begin
               w_state_nxt  = ST_WAIT_LOCK;
               w_cause_load = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Capture which conditions knocked the system out of RUN.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rst_cause <= '0;
      end else if (w_cause_load) begin
         r_rst_cause <= w_fault_vec;
      end
   end

   // Moore output decode straight from the state register.
   always_comb begin
      w_aon_pok   = 1'b0;
      w_main_pok  = 1'b0;
      w_clk_val   = '0;
      w_sys_rst_n = 1'b0;
      case (r_state)
         ST_AON: begin
            w_aon_pok = 1'b1;
         end
         ST_MAIN: begin
            w_aon_pok  = 1'b1;
            w_main_pok = 1'b1;
            w_clk_val  = ClkValAll;
         end
         ST_RUN: begin
            w_aon_pok   = 1'b1;
            w_main_pok  = 1'b1;
            w_clk_val   = ClkValAll;
            w_sys_rst_n = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign pwr.aon_pok_o   = w_aon_pok;
   assign pwr.main_pok_o  = w_main_pok;
   assign pwr.clk_val_o   = w_clk_val;
   assign pwr.sys_rst_no  = w_sys_rst_n;
   assign pwr.rst_cause_o = r_rst_cause;

`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
   localparam int c_TO_W = cnt_width(LOCK_TIMEOUT_CYCLES);
   localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(LOCK_TIMEOUT_CYCLES - 1);

   logic [c_TO_W-1:0] r_to_cnt;
   logic              r_lock_timeout;

   // Time how long the PLL stays unlocked while waiting; the flag is sticky.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_to_cnt       <= '0;
         r_lock_timeout <= 1'b0;
      end else if ((r_state == ST_WAIT_LOCK) && !w_lock_s) begin
         if (r_to_cnt == c_TO_LAST) begin
            r_lock_timeout <= 1'b1;
         end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
      end else begin
         r_to_cnt <= '0;
      end
   end

   assign pwr.lock_timeout_o = r_lock_timeout;
`else
   logic w_unused_lock_timeout_cfg;
   assign w_unused_lock_timeout_cfg = (LOCK_TIMEOUT_CYCLES > 0);
   assign pwr.lock_timeout_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpga_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_pwr_seq
// Description : Directed self-checking bench for fpga_pwr_seq with
//               SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8,
//               AON_TO_MAIN_CYCLES=2, LOCK_TIMEOUT_CYCLES=10.
//               Cycle k means "just after the k-th rising edge following
//               reset release".
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_pwr_seq;
   import fpga_pwr_seq_pkg::*;

   // Hand-derived milestones: 2 sync + 4 debounce + 8 stretch + 1 = 15
   localparam int AON_CYC  = 15;
   localparam int MAIN_CYC = 17;
   localparam int RUN_CYC  = 19;
`ifdef PWR_SEQ_LOCK_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   fpga_pwr_seq_if u_if ();

   fpga_pwr_seq #(
      .SYNC_STAGES         (2),
      .DEBOUNCE_CYCLES     (4),
      .STRETCH_CYCLES      (8),
      .AON_TO_MAIN_CYCLES  (2),
      .LOCK_TIMEOUT_CYCLES (10)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .pwr   (u_if.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_reset();
      rst = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      u_if.pll_locked_i = 1'b1;
      u_if.btn_rst_ni   = 1'b1;
      u_if.jtag_srst_ni = 1'b1;
      hold_reset();
      n_vec++; if (u_if.aon_pok_o !== 1'b0) begin n_err++; $display("FAIL reset_aon: got %b want 0", u_if.aon_pok_o); end
      n_vec++; if (u_if.main_pok_o !== 1'b0) begin n_err++; $display("FAIL reset_main: got %b want 0", u_if.main_pok_o); end
      n_vec++; if (u_if.clk_val_o !== 4'h0) begin n_err++; $display("FAIL reset_clkval: got %h want 0", u_if.clk_val_o); end
      n_vec++; if (u_if.sys_rst_no !== 1'b0) begin n_err++; $display("FAIL reset_sysrst: got %b want 0", u_if.sys_rst_no); end
      n_vec++; if (u_if.rst_cause_o !== 3'b000) begin n_err++; $display("FAIL reset_cause: got %b want 000", u_if.rst_cause_o); end
      n_vec++; if (u_if.lock_timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", u_if.lock_timeout_o); end
   endtask

   task automatic test_power_up();
      rst = 1'b0;
      for (int k = 1; k <= RUN_CYC; k++) begin
         tick();
         n_vec++; if (u_if.aon_pok_o !== (k >= AON_CYC)) begin n_err++; $display("FAIL pu_aon cyc %0d: got %b want %b", k, u_if.aon_pok_o, (k >= AON_CYC)); end
         n_vec++; if (u_if.main_pok_o !== (k >= MAIN_CYC)) begin n_err++; $display("FAIL pu_main cyc %0d: got %b want %b", k, u_if.main_pok_o, (k >= MAIN_CYC)); end
         n_vec++; if (u_if.clk_val_o !== ((k >= MAIN_CYC) ? 4'hF : 4'h0)) begin n_err++; $display("FAIL pu_clkval cyc %0d: got %h", k, u_if.clk_val_o); end
         n_vec++; if (u_if.sys_rst_no !== (k >= RUN_CYC)) begin n_err++; $display("FAIL pu_sysrst cyc %0d: got %b want %b", k, u_if.sys_rst_no, (k >= RUN_CYC)); end
      end
      n_vec++; if (u_if.rst_cause_o !== 3'b000) begin n_err++; $display("FAIL pu_cause: got %b want 000", u_if.rst_cause_o); end
   endtask

   // One-cycle lock drop from RUN: teardown on the third edge, then full replay.
   task automatic test_lock_loss();
      u_if.pll_locked_i = 1'b0;
      tick();
      u_if.pll_locked_i = 1'b1;
      tick();
      n_vec++; if (u_if.sys_rst_no !== 1'b1) begin n_err++; $display("FAIL ll_early_sysrst: got %b want 1", u_if.sys_rst_no); end
      tick();
      n_vec++; if (u_if.aon_pok_o !== 1'b0) begin n_err++; $display("FAIL ll_aon: got %b want 0", u_if.aon_pok_o); end
      n_vec++; if (u_if.main_pok_o !== 1'b0) begin n_err++; $display("FAIL ll_main: got %b want 0", u_if.main_pok_o); end
      n_vec++; if (u_if.clk_val_o !== 4'h0) begin n_err++; $display("FAIL ll_clkval: got %h want 0", u_if.clk_val_o); end
      n_vec++; if (u_if.sys_rst_no !== 1'b0) begin n_err++; $display("FAIL ll_sysrst: got %b want 0", u_if.sys_rst_no); end
      n_vec++; if (u_if.rst_cause_o !== 3'b001) begin n_err++; $display("FAIL ll_cause: got %b want 001", u_if.rst_cause_o); end
      for (int j = 3; j <= 15; j++) begin
         tick();
         n_vec++; if (u_if.aon_pok_o !== (j >= 11)) begin n_err++; $display("FAIL ll_re_aon step %0d: got %b want %b", j, u_if.aon_pok_o, (j >= 11)); end
         n_vec++; if (u_if.sys_rst_no !== (j >= 15)) begin n_err++; $display("FAIL ll_re_sysrst step %0d: got %b want %b", j, u_if.sys_rst_no, (j >= 15)); end
      end
      n_vec++; if (u_if.rst_cause_o !== 3'b001) begin n_err++; $display("FAIL ll_cause_kept: got %b want 001", u_if.rst_cause_o); end
   endtask

   task automatic test_reset_clears_cause();
      hold_reset();
      n_vec++; if (u_if.rst_cause_o !== 3'b000) begin n_err++; $display("FAIL rst_cause_clear: got %b want 000", u_if.rst_cause_o); end
      n_vec++; if (u_if.sys_rst_no !== 1'b0) begin n_err++; $display("FAIL rst_mid_sysrst: got %b want 0", u_if.sys_rst_no); end
   endtask

   // Lock glitch seen by the FSM while stretch count is 5: restart from zero.
   task automatic test_stretch_abort();
      rst = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         if (k == 11) u_if.pll_locked_i = 1'b0;
         if (k == 12) u_if.pll_locked_i = 1'b1;
         tick();
         if (k == 13) begin
            n_vec++; if (dut.r_state !== ST_WAIT_LOCK) begin n_err++; $display("FAIL sa_state: got %b want %b", dut.r_state, ST_WAIT_LOCK); end
         end
         n_vec++; if (u_if.aon_pok_o !== (k >= 22)) begin n_err++; $display("FAIL sa_aon cyc %0d: got %b want %b", k, u_if.aon_pok_o, (k >= 22)); end
      end
   endtask

   // Button toggles every 2 cycles for 20 cycles; last rising edge before edge 19.
   task automatic test_bounce();
      hold_reset();
      rst = 1'b0;
      for (int k = 1; k <= 37; k++) begin
         u_if.btn_rst_ni = (k <= 20) ? 1'(((k - 1) >> 1) & 1) : 1'b1;
         tick();
         if (k <= 24) begin
            n_vec++; if (dut.r_state === ST_STRETCH) begin n_err++; $display("FAIL bn_no_stretch cyc %0d: got %b", k, dut.r_state); end
         end
         if (k == 25) begin
            n_vec++; if (dut.r_state !== ST_STRETCH) begin n_err++; $display("FAIL bn_stretch cyc %0d: got %b want %b", k, dut.r_state, ST_STRETCH); end
         end
         n_vec++; if (u_if.aon_pok_o !== (k >= 33)) begin n_err++; $display("FAIL bn_aon cyc %0d: got %b want %b", k, u_if.aon_pok_o, (k >= 33)); end
      end
      n_vec++; if (u_if.sys_rst_no !== 1'b1) begin n_err++; $display("FAIL bn_sysrst: got %b want 1", u_if.sys_rst_no); end
   endtask

   // Button pressed 4 cycles ahead of JTAG so both faults reach the FSM together.
   task automatic test_back_to_back();
      for (int n = 0; n <= 6; n++) begin
         if (n == 0) u_if.btn_rst_ni = 1'b0;
         if (n == 4) u_if.jtag_srst_ni = 1'b0;
         tick();
         if (n == 5) begin
            n_vec++; if (u_if.sys_rst_no !== 1'b1) begin n_err++; $display("FAIL bb_sysrst_pre: got %b want 1", u_if.sys_rst_no); end
         end
         if (n == 6) begin
            n_vec++; if (u_if.sys_rst_no !== 1'b0) begin n_err++; $display("FAIL bb_sysrst: got %b want 0", u_if.sys_rst_no); end
            n_vec++; if (u_if.rst_cause_o !== 3'b110) begin n_err++; $display("FAIL bb_cause: got %b want 110", u_if.rst_cause_o); end
            n_vec++; if (u_if.clk_val_o !== 4'h0) begin n_err++; $display("FAIL bb_clkval: got %h want 0", u_if.clk_val_o); end
         end
      end
      u_if.btn_rst_ni   = 1'b1;
      u_if.jtag_srst_ni = 1'b1;
   endtask

   task automatic test_lock_timeout();
      hold_reset();
      u_if.pll_locked_i = 1'b0;
      rst = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         n_vec++; if (u_if.lock_timeout_o !== (TO_EN && (k >= 10))) begin n_err++; $display("FAIL to_flag cyc %0d: got %b want %b", k, u_if.lock_timeout_o, (TO_EN && (k >= 10))); end
      end
      u_if.pll_locked_i = 1'b1;
      repeat (20) tick();
      n_vec++; if (u_if.lock_timeout_o !== TO_EN) begin n_err++; $display("FAIL to_sticky: got %b want %b", u_if.lock_timeout_o, TO_EN); end
      n_vec++; if (u_if.aon_pok_o !== 1'b1) begin n_err++; $display("FAIL to_seq_aon: got %b want 1", u_if.aon_pok_o); end
      hold_reset();
      n_vec++; if (u_if.lock_timeout_o !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", u_if.lock_timeout_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      u_if.pll_locked_i = 1'b0;
      u_if.btn_rst_ni   = 1'b0;
      u_if.jtag_srst_ni = 1'b0;
      test_reset();
      test_power_up();
      test_lock_loss();
      test_reset_clears_cause();
      test_stretch_abort();
      test_bounce();
      test_back_to_back();
      test_lock_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
